// File: rtl/fuzz_top_pkg.sv
// Shared constants and the status-word layout for fuzz_top.
// The struct below is the low 360 bits of y; everything above it is tied to zero.
package fuzz_top_pkg;

  localparam int IN_W   = 79;
  localparam int Y_W    = 501;

  localparam int SUM_LSB  = 0;    localparam int SUM_W  = 19;
  localparam int PROD_LSB = 19;   localparam int PROD_W = 25;
  localparam int DIFF_LSB = 44;   localparam int DIFF_W = 20;
  localparam int MAX_LSB  = 64;   localparam int MAX_W  = 19;
  localparam int MIX_LSB  = 83;   localparam int MIX_W  = IN_W;
  localparam int DLY_LSB  = 162;  localparam int DLY_W  = IN_W;
  localparam int POP_LSB  = 241;  localparam int POP_W  = 7;
  localparam int CNT_LSB  = 248;  localparam int CNT_W  = 16;
  localparam int ACC_LSB  = 264;  localparam int ACC_W  = 64;
  localparam int LFSR_LSB = 328;  localparam int LFSR_W = 32;
  localparam int PAD_LSB  = 360;
  localparam int PAD_W    = Y_W - PAD_LSB;

  // Feedback taps at bits 31, 21, 1 and 0.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Field order is MSB first, so the struct lines up with the y bit map.
  typedef struct packed {
    logic [LFSR_W-1:0] lfsr;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic [POP_W-1:0]  pop;
    logic [DLY_W-1:0]  dly;
    logic [MIX_W-1:0]  mix;
    logic [MAX_W-1:0]  max;
    logic [DIFF_W-1:0] diff;
    logic [PROD_W-1:0] prod;
    logic [SUM_W-1:0]  sum;
  } status_t;

  function automatic logic [POP_W-1:0] popcount79(input logic [IN_W-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < IN_W; i++) n = n + POP_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/fuzz_lfsr32.sv
// 32-bit Fibonacci LFSR, shift-left with feedback into bit 0.
// SEED must be nonzero or the register locks at zero.
module fuzz_lfsr32
  import fuzz_top_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] state
);

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[30:0], ^(lfsr_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign state = lfsr_q;

endmodule

// File: rtl/fuzz_top.sv
// Registered mixing datapath: every input-derived field updates each clock and
// is packed into the 501-bit status word y.
module fuzz_top
  import fuzz_top_pkg::*;
#(
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [17:0]    wire0,
  input  logic [16:0]    wire1,
  input  logic [14:0]    wire2,
  input  logic [9:0]     wire3,
  input  logic [18:0]    wire4,
  output logic [Y_W-1:0] y
);

  logic [IN_W-1:0]   in_vec;
  logic [IN_W-1:0]   in_q;
  logic [LFSR_W-1:0] lfsr;
  status_t           st_q, st_d;

  logic signed [18:0] c_ext19;
  logic signed [19:0] c_ext20, e_ext20;

  assign in_vec  = {wire4, wire3, wire2, wire1, wire0};
  assign c_ext19 = {{4{wire2[14]}}, wire2};
  assign c_ext20 = {{5{wire2[14]}}, wire2};
  assign e_ext20 = {wire4[18], wire4};

  always_comb begin
    st_d      = st_q;
    st_d.sum  = SUM_W'(wire0) + SUM_W'(wire1);
    st_d.prod = PROD_W'($signed(wire3) * $signed(wire2));
    st_d.diff = e_ext20 - c_ext20;
    st_d.max  = ($signed(wire4) >= c_ext19) ? wire4 : c_ext19;
    st_d.mix  = in_vec ^ {st_q.mix[IN_W-2:0], st_q.mix[IN_W-1]};
    st_d.dly  = in_q;
    st_d.pop  = popcount79(in_vec);
    st_d.cnt  = st_q.cnt + 1'b1;
    // Accumulates the registered product, so it trails the operands by two edges.
    st_d.acc  = st_q.acc + {{(ACC_W-PROD_W){st_q.prod[PROD_W-1]}}, st_q.prod};
    st_d.lfsr = lfsr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q <= '0;
      st_q <= '0;
    end else begin
      in_q <= in_vec;
      st_q <= st_d;
    end
  end

  fuzz_lfsr32 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .state (lfsr)
  );

  // The LFSR flop lives in the sub-module; the struct copy of it is unused.
  status_t st_out;
  always_comb begin
    st_out      = st_q;
    st_out.lfsr = lfsr;
  end

  assign y = {{PAD_W{1'b0}}, st_out};

endmodule

// File: tb/tb_fuzz_top.sv
// Directed-vector bench for fuzz_top; expected values are worked out by hand.
module tb_fuzz_top;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [17:0]  wire0 = '0;
  logic [16:0]  wire1 = '0;
  logic [14:0]  wire2 = '0;
  logic [9:0]   wire3 = '0;
  logic [18:0]  wire4 = '0;
  logic [500:0] y;

  int pass_cnt = 0;
  int total    = 0;

  fuzz_top #(.LFSR_SEED(32'h0000_0001)) dut (
    .clk(clk), .rst_n(rst_n), .wire0(wire0), .wire1(wire1),
    .wire2(wire2), .wire3(wire3), .wire4(wire4), .y(y)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [78:0] v);
    {wire4, wire3, wire2, wire1, wire0} = v;
  endtask

  // Short reset pulse between edges; inputs left at zero.
  task automatic do_reset();
    set_in('0);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [500:0] exp_y;
    exp_y = '0;
    exp_y[359:328] = 32'h1;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in({$urandom(), $urandom(), $urandom()});
      tick();
      total++;
      if (y !== exp_y) $display("FAIL reset_hold[%0d]: got %h want %h", i, y, exp_y);
      else pass_cnt++;
    end
    set_in('0);
    rst_n = 1'b1;
    tick();
    total++;
    if (y[263:248] !== 16'd1) $display("FAIL reset_cnt1: got %h want 0001", y[263:248]);
    else pass_cnt++;
    total++;
    if (y[359:328] !== 32'h3) $display("FAIL reset_lfsr1: got %h want 00000003", y[359:328]);
    else pass_cnt++;
    tick();
    total++;
    if (y[359:328] !== 32'h6) $display("FAIL lfsr2: got %h want 00000006", y[359:328]);
    else pass_cnt++;
    tick();
    total++;
    if (y[359:328] !== 32'hD) $display("FAIL lfsr3: got %h want 0000000d", y[359:328]);
    else pass_cnt++;
  endtask

  task automatic test_sum_pop();
    do_reset();
    wire0 = 18'h3FFFF;
    wire1 = 17'h1FFFF;
    tick();
    total++;
    if (y[18:0] !== 19'h5FFFE) $display("FAIL sum_max: got %h want 5fffe", y[18:0]);
    else pass_cnt++;
    total++;
    if (y[247:241] !== 7'd35) $display("FAIL pop35: got %0d want 35", y[247:241]);
    else pass_cnt++;
    total++;
    if (y[500:360] !== '0) $display("FAIL pad_zero: got %h want 0", y[500:360]);
    else pass_cnt++;
  endtask

  // -1 * 16383 = -16383 = 25'h1FFC001
  task automatic test_prod_acc();
    do_reset();
    wire3 = 10'h3FF;
    wire2 = 15'h3FFF;
    tick();
    total++;
    if (y[43:19] !== 25'h1FFC001) $display("FAIL prod: got %h want 1ffc001", y[43:19]);
    else pass_cnt++;
    total++;
    if (y[327:264] !== 64'h0) $display("FAIL acc_e1: got %h want 0", y[327:264]);
    else pass_cnt++;
    tick();
    total++;
    if (y[327:264] !== 64'hFFFF_FFFF_FFFF_C001)
      $display("FAIL acc_e2: got %h want ffffffffffffc001", y[327:264]);
    else pass_cnt++;
    tick();
    total++;
    if (y[327:264] !== 64'hFFFF_FFFF_FFFF_8002)
      $display("FAIL acc_e3: got %h want ffffffffffff8002", y[327:264]);
    else pass_cnt++;
  endtask

  task automatic test_diff_max();
    do_reset();
    wire4 = 19'h40000;
    wire2 = 15'h0001;
    tick();
    total++;
    if (y[63:44] !== 20'hBFFFF) $display("FAIL diff_min: got %h want bffff", y[63:44]);
    else pass_cnt++;
    total++;
    if (y[82:64] !== 19'h00001) $display("FAIL max_c: got %h want 00001", y[82:64]);
    else pass_cnt++;
    wire4 = 19'h1;
    wire2 = 15'h1;
    tick();
    total++;
    if (y[82:64] !== 19'h00001) $display("FAIL max_tie: got %h want 00001", y[82:64]);
    else pass_cnt++;
    // E=-1, C=-16384: max is E, diff is +16383
    wire4 = 19'h7FFFF;
    wire2 = 15'h4000;
    tick();
    total++;
    if (y[82:64] !== 19'h7FFFF) $display("FAIL max_neg: got %h want 7ffff", y[82:64]);
    else pass_cnt++;
    total++;
    if (y[63:44] !== 20'h03FFF) $display("FAIL diff_neg: got %h want 03fff", y[63:44]);
    else pass_cnt++;
  endtask

  task automatic test_mix_dly();
    logic [78:0] ones;
    ones = '1;
    do_reset();
    set_in(ones);
    tick();
    total++;
    if (y[161:83] !== ones) $display("FAIL mix_e1: got %h want all ones", y[161:83]);
    else pass_cnt++;
    total++;
    if (y[247:241] !== 7'h4F) $display("FAIL pop79: got %h want 4f", y[247:241]);
    else pass_cnt++;
    total++;
    if (y[240:162] !== '0) $display("FAIL dly_e1: got %h want 0", y[240:162]);
    else pass_cnt++;
    tick();
    total++;
    if (y[161:83] !== '0) $display("FAIL mix_e2: got %h want 0", y[161:83]);
    else pass_cnt++;
    total++;
    if (y[240:162] !== ones) $display("FAIL dly_e2: got %h want all ones", y[240:162]);
    else pass_cnt++;
    // Single set bit then zero input: rotate-left moves it to bit 1.
    do_reset();
    set_in(79'h1);
    tick();
    set_in('0);
    tick();
    total++;
    if (y[161:83] !== 79'h2) $display("FAIL mix_rot: got %h want 2", y[161:83]);
    else pass_cnt++;
  endtask

  task automatic test_wrap_async();
    logic         lfsr_zero;
    logic [500:0] exp_y;
    lfsr_zero = 1'b0;
    do_reset();
    wire0 = 18'h00055;
    for (int i = 0; i < 65536; i++) begin
      tick();
      if (y[359:328] == 32'h0) lfsr_zero = 1'b1;
    end
    total++;
    if (y[263:248] !== 16'h0) $display("FAIL cnt_wrap: got %h want 0000", y[263:248]);
    else pass_cnt++;
    total++;
    if (lfsr_zero !== 1'b0) $display("FAIL lfsr_nonzero: got zero state want never zero");
    else pass_cnt++;
    // Reset mid-cycle must clear without any clock edge.
    exp_y = '0;
    exp_y[359:328] = 32'h1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (y !== exp_y) $display("FAIL async_clear: got %h want %h", y, exp_y);
    else pass_cnt++;
    #1;
    rst_n = 1'b1;
    tick();
    total++;
    if (y[263:248] !== 16'd1) $display("FAIL cnt_after_rel: got %h want 0001", y[263:248]);
    else pass_cnt++;
    total++;
    if (y[18:0] !== 19'h00055) $display("FAIL sum_after_rel: got %h want 00055", y[18:0]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sum_pop();
    test_prod_acc();
    test_diff_max();
    test_mix_dly();
    test_wrap_async();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
